salsa_stream_xor: RTL and testbench

SALSA_STREAM_XOR -- requirements
Module: salsa_stream_xor

---
 rtl/salsa_stream_xor.sv | 223 ++++++++++++++++++++++
 tb/tb_salsa_stream_xor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/salsa_stream_xor.sv
// rtl/salsa_stream_xor.sv - Salsa20 keystream XOR engine for 32-bit valid/ready word streams
//
// salsa_hash: combinational Salsa20 core (20 rounds plus feed-forward add).
//   i_key[255:0], i_nonce[63:0], i_counter[63:0] -> o_digest[511:0], word i at [32*i+31:32*i].
//
// salsa_stream_xor: XORs each accepted input word with the next keystream word.
//   clk, rst (sync, active-high)
//   start       : pulse; latches key_in/nonce_in/counter_in and restarts the stream
//   in_data/in_valid/in_ready    : upstream word handshake
//   out_data/out_valid/out_ready : downstream word handshake (single output register)
//   busy        : any state other than IDLE
//   wrap_err    : sticky block-counter wrap flag
// Parameter HASH_STAGE_CYC (1-15): cycles the hash input is held before the digest is captured.
// Optional feature macro SALSA_WRAP_GUARD_EN: halt with wrap_err on counter wrap instead of wrapping.

module salsa_hash (
  input  logic [255:0] i_key,
  input  logic [63:0]  i_nonce,
  input  logic [63:0]  i_counter,
  output logic [511:0] o_digest
);

  function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] s);
    logic [63:0] t;
    t = {v, v} << s;
    return t[63:32];
  endfunction

  function automatic logic [15:0][31:0] qr(input logic [15:0][31:0] st,
                                           input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] c, input logic [3:0] d);
    logic [15:0][31:0] x;
    x    = st;
    x[b] = x[b] ^ rotl(x[a] + x[d], 5'd7);
    x[c] = x[c] ^ rotl(x[b] + x[a], 5'd9);
    x[d] = x[d] ^ rotl(x[c] + x[b], 5'd13);
    x[a] = x[a] ^ rotl(x[d] + x[c], 5'd18);
    return x;
  endfunction

  logic [15:0][31:0] w_init;
  logic [15:0][31:0] w_x;

  always_comb begin
    // "expand 32-byte k" constants on the diagonal, key split around nonce/counter
    w_init[0]  = 32'h6170_7865;
    w_init[5]  = 32'h3320_646e;
    w_init[10] = 32'h7962_2d32;
    w_init[15] = 32'h6b20_6574;
    for (int i = 0; i < 4; i++) begin
      w_init[1 + i]  = i_key[32*i +: 32];
      w_init[11 + i] = i_key[128 + 32*i +: 32];
    end
    w_init[6] = i_nonce[31:0];
    w_init[7] = i_nonce[63:32];
    w_init[8] = i_counter[31:0];
    w_init[9] = i_counter[63:32];

    w_x = w_init;
    for (int r = 0; r < 10; r++) begin
      // column round
      w_x = qr(w_x, 4'd0,  4'd4,  4'd8,  4'd12);
      w_x = qr(w_x, 4'd5,  4'd9,  4'd13, 4'd1);
      w_x = qr(w_x, 4'd10, 4'd14, 4'd2,  4'd6);
      w_x = qr(w_x, 4'd15, 4'd3,  4'd7,  4'd11);
      // row round
      w_x = qr(w_x, 4'd0,  4'd1,  4'd2,  4'd3);
      w_x = qr(w_x, 4'd5,  4'd6,  4'd7,  4'd4);
      w_x = qr(w_x, 4'd10, 4'd11, 4'd8,  4'd9);
      w_x = qr(w_x, 4'd15, 4'd12, 4'd13, 4'd14);
    end

    for (int i = 0; i < 16; i++) begin
      o_digest[32*i +: 32] = w_x[i] + w_init[i];
    end
  end

endmodule

module salsa_stream_xor #(
  parameter int HASH_STAGE_CYC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key_in,
  input  logic [63:0]  nonce_in,
  input  logic [63:0]  counter_in,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         wrap_err
);

  typedef enum logic [1:0] {IDLE, GEN, STREAM, HALT} state_t;

  localparam logic [3:0] CYC_LOAD = 4'(HASH_STAGE_CYC);

  state_t        r_state;
  state_t        w_next;
  logic [255:0]  r_key;
  logic [63:0]   r_nonce;
  logic [63:0]   r_counter;
  logic [511:0]  r_ks;
  logic [511:0]  w_digest;
  logic [3:0]    r_idx;
  logic [3:0]    r_cyc;
  logic [31:0]   r_out_data;
  logic          r_out_valid;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_last;
  logic          w_wrap;

  salsa_hash u_hash (
    .i_key     (r_key),
    .i_nonce   (r_nonce),
    .i_counter (r_counter),
    .o_digest  (w_digest)
  );

  assign w_accept = in_valid & w_in_ready;
  assign w_last   = w_accept & (r_idx == 4'd15);

`ifdef SALSA_WRAP_GUARD_EN
  logic r_wrap_err;

  assign w_wrap   = w_last & (&r_counter);
  assign wrap_err = r_wrap_err;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_wrap_err <= 1'b0;
    end else if (w_wrap) begin
      r_wrap_err <= 1'b1;
    end
  end
`else
  assign w_wrap   = 1'b0;
  assign wrap_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = GEN;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        GEN:     if (r_cyc == 4'd1) w_next = STREAM;
        STREAM:  if (w_wrap) w_next = HALT;
                 else if (w_last) w_next = GEN;
        HALT:    w_next = HALT;
        default: w_next = IDLE;
      endcase
    end
  end

  // start and rst win over any handshake in the same cycle, so never offer ready then
  always_comb begin
    w_in_ready = 1'b0;
    if (r_state == STREAM && !start && !rst) begin
      w_in_ready = ~r_out_valid | out_ready;
    end
    busy = (r_state != IDLE);
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key       <= '0;
      r_nonce     <= '0;
      r_counter   <= '0;
      r_ks        <= '0;
      r_idx       <= '0;
      r_cyc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (start) begin
      r_key       <= key_in;
      r_nonce     <= nonce_in;
      r_counter   <= counter_in;
      r_idx       <= '0;
      r_cyc       <= CYC_LOAD;
      r_out_valid <= 1'b0;
    end else begin
      if (r_state == GEN) begin
        r_cyc <= r_cyc - 4'd1;
        if (r_cyc == 4'd1) begin
          r_ks <= w_digest;
        end
      end
      // the output register drains independently of state, so GEN/HALT never stall it
      if (w_accept) begin
        r_out_data  <= in_data ^ r_ks[{r_idx, 5'd0} +: 32];
        r_out_valid <= 1'b1;
        r_idx       <= r_idx + 4'd1;
        if (r_idx == 4'd15) begin
          r_counter <= r_counter + 64'd1;
          r_cyc     <= CYC_LOAD;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_salsa_stream_xor.sv
// tb/tb_salsa_stream_xor.sv - table-driven directed bench for salsa_stream_xor
module tb_salsa_stream_xor;

  localparam int P = 1;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, out_ready;
  logic         in_ready, out_valid, busy, wrap_err;
  logic [255:0] key_in;
  logic [63:0]  nonce_in, counter_in;
  logic [31:0]  in_data, out_data;

  always #5 clk = ~clk;

  salsa_stream_xor #(.HASH_STAGE_CYC(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .nonce_in   (nonce_in),
    .counter_in (counter_in),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .wrap_err   (wrap_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]  exp_q[$];
  logic [255:0] m_key;
  logic [63:0]  m_nonce, m_ctr;
  logic [511:0] m_ks;
  int           m_idx = 0;
  logic         s_rdy, s_acc;

  localparam int QI [8][4] = '{'{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11},
                               '{0, 1, 2, 3},  '{5, 6, 7, 4},  '{10, 11, 8, 9}, '{15, 12, 13, 14}};

  function automatic logic [31:0] rol(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [511:0] salsa_model(input logic [255:0] k, input logic [63:0] n,
                                               input logic [63:0] c);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[5] = 32'h3320646e; s[10] = 32'h79622d32; s[15] = 32'h6b206574;
    for (int i = 0; i < 4; i++) begin
      s[1 + i]  = k[32*i +: 32];
      s[11 + i] = k[128 + 32*i +: 32];
    end
    s[6] = n[31:0]; s[7] = n[63:32]; s[8] = c[31:0]; s[9] = c[63:32];
    x = s;
    for (int dr = 0; dr < 10; dr++) begin
      for (int qn = 0; qn < 8; qn++) begin
        int a, b, c2, d;
        a = QI[qn][0]; b = QI[qn][1]; c2 = QI[qn][2]; d = QI[qn][3];
        x[b]  = x[b]  ^ rol(x[a]  + x[d],  7);
        x[c2] = x[c2] ^ rol(x[b]  + x[a],  9);
        x[d]  = x[d]  ^ rol(x[c2] + x[b],  13);
        x[a]  = x[a]  ^ rol(x[d]  + x[c2], 18);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called at a negedge; samples mid-low-phase, updates scoreboard, returns at next negedge
  task automatic tick();
    #1;
    s_rdy = in_ready;
    s_acc = in_valid & in_ready & !start & !rst;
    if (!start && !rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out_unexpected: got word %h with no word pending", out_data);
        end else begin
          chk("out_word", 64'(out_data), 64'(exp_q.pop_front()));
        end
      end
      if (s_acc) begin
        exp_q.push_back(in_data ^ m_ks[32*m_idx +: 32]);
        m_idx++;
        if (m_idx == 16) begin
          m_idx = 0;
          m_ctr = m_ctr + 64'd1;
          m_ks  = salsa_model(m_key, m_nonce, m_ctr);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_start(input logic [255:0] k, input logic [63:0] n, input logic [63:0] c);
    key_in = k; nonce_in = n; counter_in = c;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    start = 1'b0;
    key_in = '1; nonce_in = '1; counter_in = '1;
    exp_q.delete();
    m_key = k; m_nonce = n; m_ctr = c; m_idx = 0;
    m_ks = salsa_model(k, n, c);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_idx = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_wrap_err"},  64'(wrap_err),  64'd0);
  endtask

  task automatic feed(input int n, input logic [31:0] base, input logic [31:0] step,
                      output int wait_cnt, output int low_cnt);
    int got = 0;
    int budget = 0;
    wait_cnt = 0;
    low_cnt  = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (got < n && budget < 4*n + 40) begin
      in_data = base + step * 32'(got);
      tick();
      if (s_acc) got++;
      else if (got == 0) wait_cnt++;
      else low_cnt++;
      budget++;
    end
    in_valid = 1'b0;
    if (got < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL feed_timeout: accepted %0d words, required %0d", got, n);
    end
  endtask

  task automatic drain();
    int b = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && b < 20) begin
      tick();
      b++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  typedef struct {
    logic [255:0] key;
    logic [63:0]  nonce;
    logic [63:0]  ctr;
    logic [31:0]  base;
    logic [31:0]  step;
    int           n;
  } vec_t;

  vec_t vt[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, l, cnt, bsy;
    logic [511:0] blk;
    logic [31:0]  exp0;

    vt[0] = '{256'h0, 64'h0, 64'h0, 32'h0, 32'h0, 16};
    vt[1] = '{256'h0, 64'h0, 64'h0, 32'hA5A5_A5A5, 32'h0, 48};
    vt[2] = '{256'h00112233445566778899AABBCCDDEEFF_0123456789ABCDEF_FEDCBA9876543210,
              64'hDEADBEEF_CAFEF00D, 64'h0000_0000_FFFF_FFFF, 32'h1000_0000, 32'h0101_0101, 20};
    vt[3] = '{{8{32'h8BAD_F00D}}, 64'h1, 64'd7, 32'hFFFF_FFFF, 32'h3, 5};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; key_in = '0; nonce_in = '0; counter_in = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");

    for (int v = 0; v < 4; v++) begin
      do_start(vt[v].key, vt[v].nonce, vt[v].ctr);
      feed(vt[v].n, vt[v].base, vt[v].step, w, l);
      chk($sformatf("vec%0d_first_ready_latency", v), 64'(w), 64'(P));
      chk($sformatf("vec%0d_refill_low_cycles", v), 64'(l), 64'(((vt[v].n - 1) / 16) * P));
      drain();
    end

    // output backpressure right after the first word
    do_start(vt[2].key, vt[2].nonce, 64'd3);
    blk = salsa_model(vt[2].key, vt[2].nonce, 64'd3);
    exp0 = 32'h1357_9BDF ^ blk[31:0];
    in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h1357_9BDF;
    cnt = 0;
    do begin tick(); cnt++; end while (!s_acc && cnt < 10);
    in_data = 32'h2468_ACE0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", 64'(s_rdy), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_data", 64'(out_data), 64'(exp0));
    end
    feed(15, 32'h2468_ACE0, 32'h11, w, l);
    chk("bp_release_no_bubble", 64'(w), 64'd0);
    drain();

    // restart mid-block at idx 7 with a word still pending
    do_start(vt[3].key, vt[3].nonce, 64'd9);
    feed(7, 32'h0F0F_0000, 32'h1, w, l);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("mid_pending_valid", 64'(out_valid), 64'd1);
    do_start(vt[2].key, vt[2].nonce, 64'd5);
    chk("mid_out_valid_cleared", 64'(out_valid), 64'd0);
    feed(16, 32'hCAFE_0000, 32'h1, w, l);
    chk("mid_restart_latency", 64'(w), 64'(P));
    drain();

    // block counter at all-ones
    do_start(vt[3].key, vt[3].nonce, 64'hFFFF_FFFF_FFFF_FFFF);
    feed(16, 32'h7777_0000, 32'h3, w, l);
`ifdef SALSA_WRAP_GUARD_EN
    in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h5555_AAAA;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_rdy) cnt++;
    end
    chk("wrap_in_ready_held_low", 64'(cnt), 64'd0);
    chk("wrap_err_set", 64'(wrap_err), 64'd1);
    chk("wrap_busy", 64'(busy), 64'd1);
    chk("wrap_drained", 64'(exp_q.size()), 64'd0);
    do_start(vt[3].key, vt[3].nonce, 64'd0);
    chk("wrap_err_cleared_by_start", 64'(wrap_err), 64'd0);
`else
    feed(1, 32'h5555_AAAA, 32'h0, w, l);
    chk("wrap_next_block_latency", 64'(w), 64'(P));
    drain();
    chk("wrap_err_tied_low", 64'(wrap_err), 64'd0);
`endif

    // reset during GEN
    do_start(vt[2].key, vt[2].nonce, 64'd1);
    do_rst();
    chk_zero("rst_gen");

    // reset during STREAM with a word pending
    do_start(vt[2].key, vt[2].nonce, 64'd2);
    feed(3, 32'hABCD_0000, 32'h1, w, l);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("rst_stream_pending_valid", 64'(out_valid), 64'd1);
    do_rst();
    chk_zero("rst_stream");
    in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h1111_2222;
    cnt = 0;
    bsy = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid || s_rdy) cnt++;
      if (busy) bsy++;
    end
    chk("post_rst_no_output", 64'(cnt), 64'd0);
    chk("post_rst_idle", 64'(bsy), 64'd0);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
